// File: rtl/sram_like_axi_arbiter_if.sv
// Port bundle for the N-channel sram-like to AXI3 arbiter: sram-like master
// ports (per-channel vectors) plus the single AXI3 master port.
interface sram_like_axi_arbiter_if #(
    parameter int NUM_CH = 2
);
    // sram-like side
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    wr;
    logic [2*NUM_CH-1:0]  size;
    logic [32*NUM_CH-1:0] addr;
    logic [32*NUM_CH-1:0] wdata;
    logic [4*NUM_CH-1:0]  len;
    logic [NUM_CH-1:0]    addr_ok;
    logic [NUM_CH-1:0]    data_ok;
    logic [31:0]          rdata_o;
    logic                 data_last;
    // AXI3 side
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] axi_wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // The arbiter: slave to the sram-like masters, master on AXI.
    modport master (
        input  req, wr, size, addr, wdata, len,
        output addr_ok, data_ok, rdata_o, data_last,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, axi_wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    // The environment: sram-like masters plus the AXI slave.
    modport slave (
        output req, wr, size, addr, wdata, len,
        input  addr_ok, data_ok, rdata_o, data_last,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, axi_wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_like_axi_arbiter.sv
// Round-robin arbiter from NUM_CH sram-like master ports onto one AXI3 master,
// one transaction at a time, with incrementing read bursts and per-beat data_ok.
module sram_like_axi_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ID_BASE = 0
) (
    input logic                     clk,
    input logic                     rst,
    sram_like_axi_arbiter_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        B    = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CH_W-1:0] rr_ptr_r;
    logic [CH_W-1:0] gnt_r;
    logic [CH_W-1:0] gnt_idx_s;
    logic [CH_W-1:0] cand_s;
    logic            found_any_s;
    logic            gnt_valid_s;
    logic [31:0]     addr_r;
    logic [31:0]     wdata_r;
    logic [1:0]      size_r;
    logic [3:0]      len_r;
    logic            wr_r;
    logic            aw_done_r;
    logic            w_done_r;
    logic            aw_done_s;
    logic            w_done_s;
    logic [3:0]      id_s;
    logic [2:0]      axsize_s;
    logic            unused_s;

    function automatic logic [3:0] wstrb_for(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    wstrb_for = 4'b0001 << lo;
            2'd1:    wstrb_for = 4'b0011 << {lo[1], 1'b0};
            default: wstrb_for = 4'b1111;
        endcase
    endfunction

    // Round-robin pick: scanning downwards leaves the first requester at or after rr_ptr.
    always_comb begin
        found_any_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand_s = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
            if (bus.req[cand_s]) begin
                found_any_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                found_any_s = found_any_s;
            end
        end
    end

    assign gnt_valid_s = found_any_s & ~rst & (state_r == IDLE);
    assign id_s        = 4'(ID_BASE + int'(gnt_r));
    assign axsize_s    = {1'b0, (size_r == 2'd3) ? 2'd2 : size_r};
    assign unused_s    = ^{bus.rid, bus.rresp, bus.bid, bus.bresp, wr_r};

    // Write address and data channels complete independently; both must land before B.
    assign aw_done_s = aw_done_r | ((state_r == AW) & bus.awready);
    assign w_done_s  = w_done_r  | ((state_r == AW) & bus.wready);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) state_s = bus.wr[gnt_idx_s] ? AW : AR;
                else             state_s = IDLE;
            end
            AR: begin
                if (bus.arready) state_s = R;
                else             state_s = AR;
            end
            R: begin
                if (bus.rvalid && bus.rlast) state_s = IDLE;
                else                         state_s = R;
            end
            AW: begin
                if (aw_done_s && w_done_s) state_s = B;
                else                       state_s = AW;
            end
            B: begin
                if (bus.bvalid) state_s = IDLE;
                else            state_s = B;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, round-robin pointer and captured request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            gnt_r     <= '0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            size_r    <= 2'd0;
            len_r     <= 4'd0;
            wr_r      <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            aw_done_r <= (state_r == AW && state_s == AW) ? aw_done_s : 1'b0;
            w_done_r  <= (state_r == AW && state_s == AW) ? w_done_s : 1'b0;
            if (gnt_valid_s) begin
                gnt_r    <= gnt_idx_s;
                rr_ptr_r <= CH_W'((int'(gnt_idx_s) + 1) % NUM_CH);
                addr_r   <= bus.addr[int'(gnt_idx_s)*32 +: 32];
                wdata_r  <= bus.wdata[int'(gnt_idx_s)*32 +: 32];
                size_r   <= bus.size[int'(gnt_idx_s)*2 +: 2];
                len_r    <= bus.len[int'(gnt_idx_s)*4 +: 4];
                wr_r     <= bus.wr[gnt_idx_s];
            end else begin
                gnt_r    <= gnt_r;
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // sram-like handshakes: addr_ok on the grant cycle, data_ok per R beat or on B.
    always_comb begin
        bus.addr_ok   = '0;
        bus.data_ok   = '0;
        bus.data_last = 1'b0;
        bus.rdata_o   = bus.rdata;
        if (gnt_valid_s) bus.addr_ok[gnt_idx_s] = 1'b1;
        else             bus.addr_ok = '0;
        case (state_r)
            R: begin
                if (bus.rvalid) begin
                    bus.data_ok[gnt_r] = 1'b1;
                    bus.data_last      = bus.rlast;
                end else begin
                    bus.data_last = 1'b0;
                end
            end
            B: begin
                if (bus.bvalid) begin
                    bus.data_ok[gnt_r] = 1'b1;
                    bus.data_last      = 1'b1;
                end else begin
                    bus.data_last = 1'b0;
                end
            end
            default: bus.data_last = 1'b0;
        endcase
    end

    assign bus.arid      = id_s;
    assign bus.araddr    = addr_r;
    assign bus.arlen     = len_r;
    assign bus.arsize    = axsize_s;
    assign bus.arburst   = 2'b01;
    assign bus.arlock    = 2'b00;
    assign bus.arcache   = 4'b0000;
    assign bus.arprot    = 3'b000;
    assign bus.arvalid   = (state_r == AR);
    assign bus.rready    = (state_r == R);
    assign bus.awid      = id_s;
    assign bus.awaddr    = addr_r;
    assign bus.awlen     = 4'd0;
    assign bus.awsize    = axsize_s;
    assign bus.awburst   = 2'b01;
    assign bus.awlock    = 2'b00;
    assign bus.awcache   = 4'b0000;
    assign bus.awprot    = 3'b000;
    assign bus.awvalid   = (state_r == AW) & ~aw_done_r;
    assign bus.wid       = id_s;
    assign bus.axi_wdata = wdata_r;
    assign bus.wstrb     = wstrb_for(size_r, addr_r[1:0]);
    assign bus.wlast     = 1'b1;
    assign bus.wvalid    = (state_r == AW) & ~w_done_r;
    assign bus.bready    = (state_r == B);
endmodule

// File: tb/tb_sram_like_axi_arbiter.sv
// Directed bench: cycle-by-cycle vector table on a 2-channel arbiter, then a
// short hand sequence on a 4-channel arbiter with ID_BASE=4.
module tb_sram_like_axi_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    sram_like_axi_arbiter_if #(.NUM_CH(2)) bus ();
    sram_like_axi_arbiter_if #(.NUM_CH(4)) bus4 ();

    sram_like_axi_arbiter #(.NUM_CH(2), .ID_BASE(0)) dut (.clk(clk), .rst(rst), .bus(bus));
    sram_like_axi_arbiter #(.NUM_CH(4), .ID_BASE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // hs = {addr_ok[1:0], data_ok[1:0], data_last, arvalid, rready, awvalid, wvalid, bready}
    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  len;
        logic        ar_rdy;
        logic        rv;
        logic        rl;
        logic [31:0] rd;
        logic        aw_rdy;
        logic        w_rdy;
        logic        bv;
        logic [9:0]  hs;
        logic [3:0]  id;
        logic [3:0]  eln;
        logic [2:0]  esz;
        logic [31:0] ead;
        logic [3:0]  strb;
        logic [31:0] rdo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p_rst, input logic [1:0] p_req, input logic [1:0] p_wr,
                                input logic [1:0] p_sz, input logic [31:0] p_addr, input logic [3:0] p_len,
                                input logic p_ar, input logic p_rv, input logic p_rl, input logic [31:0] p_rd,
                                input logic p_aw, input logic p_w, input logic p_bv, input logic [9:0] p_hs,
                                input logic [3:0] p_id, input logic [3:0] p_eln, input logic [2:0] p_esz,
                                input logic [31:0] p_ead, input logic [3:0] p_strb, input logic [31:0] p_rdo);
        vec_t v;
        v.rst = p_rst;   v.req = p_req;   v.wr = p_wr;   v.sz = p_sz;     v.addr = p_addr;
        v.len = p_len;   v.ar_rdy = p_ar; v.rv = p_rv;   v.rl = p_rl;     v.rd = p_rd;
        v.aw_rdy = p_aw; v.w_rdy = p_w;   v.bv = p_bv;   v.hs = p_hs;     v.id = p_id;
        v.eln = p_eln;   v.esz = p_esz;   v.ead = p_ead; v.strb = p_strb; v.rdo = p_rdo;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        bus.req = 2'b00; bus.wr = 2'b00; bus.size = 4'd0; bus.addr = 64'd0; bus.len = 8'd0;
        bus.wdata = {2{32'h1122_3344}};
        bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0; bus.rresp = 2'd0; bus.rlast = 1'b0;
        bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; bus.bid = 4'd0; bus.bresp = 2'd0;
        bus.bvalid = 1'b0;
        bus4.req = 4'b0000; bus4.wr = 4'b0000; bus4.size = {4{2'd2}}; bus4.len = 16'd0;
        bus4.addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
        bus4.wdata = 128'd0;
        bus4.arready = 1'b0; bus4.rid = 4'd0; bus4.rdata = 32'd0; bus4.rresp = 2'd0; bus4.rlast = 1'b0;
        bus4.rvalid = 1'b0; bus4.awready = 1'b0; bus4.wready = 1'b0; bus4.bid = 4'd0; bus4.bresp = 2'd0;
        bus4.bvalid = 1'b0;

        // reset
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // ch0 single word read, zero-wait slave
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 2'd2, 32'h1FC0_0000, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b01_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd2, 32'h1FC0_0000, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_1_0_0_0_0, 4'd0, 4'd0, 3'd2, 32'h1FC0_0000, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 10'b00_01_1_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // ch1 4-beat burst, one AR wait and one R gap
        vecs.push_back(mk(1'b0, 2'b10, 2'b00, 2'd2, 32'h0000_0100, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b10_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd2, 32'h0000_0100, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_1_0_0_0_0, 4'd1, 4'd3, 3'd2, 32'h0000_0100, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd2, 32'h0000_0100, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_1_0_0_0_0, 4'd1, 4'd3, 3'd2, 32'h0000_0100, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hA0A0_A0A0, 1'b0, 1'b0, 1'b0, 10'b00_10_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hA0A0_A0A0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hA1A1_A1A1, 1'b0, 1'b0, 1'b0, 10'b00_10_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hA1A1_A1A1));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hA2A2_A2A2, 1'b0, 1'b0, 1'b0, 10'b00_10_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hA2A2_A2A2));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 32'hA3A3_A3A3, 1'b0, 1'b0, 1'b0, 10'b00_10_1_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hA3A3_A3A3));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // both channels requesting continuously: grants 0,1,0,1
        for (int g = 0; g < 4; g++) begin
            vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'd2, 32'h0000_0040, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, (g % 2 == 0) ? 10'b01_00_0_0_0_0_0_0 : 10'b10_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
            vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'd2, 32'h0000_0040, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_1_0_0_0_0, 4'(g % 2), 4'd0, 3'd2, 32'h0000_0040, 4'b0000, 32'h0));
            vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'd2, 32'h0000_0040, 4'd0, 1'b0, 1'b1, 1'b1, 32'h5555_0000 + 32'(g), 1'b0, 1'b0, 1'b0, (g % 2 == 0) ? 10'b00_01_1_0_1_0_0_0 : 10'b00_10_1_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h5555_0000 + 32'(g)));
        end
        // byte write ch0 at offset 3
        vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'd0, 32'h8000_0003, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b01_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h8000_0003, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 10'b00_00_0_0_0_1_1_0, 4'd0, 4'd0, 3'd0, 32'h8000_0003, 4'b1000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_1, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'b00_01_1_0_0_0_0_1, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // halfword write ch1 at offset 2
        vecs.push_back(mk(1'b0, 2'b10, 2'b10, 2'd1, 32'h8000_0002, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b10_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd1, 32'h8000_0002, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 10'b00_00_0_0_0_1_1_0, 4'd1, 4'd0, 3'd1, 32'h8000_0002, 4'b1100, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'b00_10_1_0_0_0_0_1, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // word write ch0
        vecs.push_back(mk(1'b0, 2'b01, 2'b01, 2'd2, 32'h8000_0008, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b01_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd2, 32'h8000_0008, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 10'b00_00_0_0_0_1_1_0, 4'd0, 4'd0, 3'd2, 32'h8000_0008, 4'b1111, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'b00_01_1_0_0_0_0_1, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // size-3 write ch1, awready 3 cycles after wready
        vecs.push_back(mk(1'b0, 2'b10, 2'b10, 2'd3, 32'h8000_000C, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b10_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd3, 32'h8000_000C, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 10'b00_00_0_0_0_1_1_0, 4'd1, 4'd0, 3'd2, 32'h8000_000C, 4'b1111, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd3, 32'h8000_000C, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_1_0_0, 4'd1, 4'd0, 3'd2, 32'h8000_000C, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd3, 32'h8000_000C, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_1_0_0, 4'd1, 4'd0, 3'd2, 32'h8000_000C, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd3, 32'h8000_000C, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 10'b00_00_0_0_0_1_0_0, 4'd1, 4'd0, 3'd2, 32'h8000_000C, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_1, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 10'b00_10_1_0_0_0_0_1, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // reset in the middle of a 4-beat burst after 2 beats
        vecs.push_back(mk(1'b0, 2'b01, 2'b00, 2'd2, 32'h0000_0200, 4'd3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b01_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd2, 32'h0000_0200, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_1_0_0_0_0, 4'd0, 4'd3, 3'd2, 32'h0000_0200, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hB0B0_B0B0, 1'b0, 1'b0, 1'b0, 10'b00_01_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hB0B0_B0B0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hB1B1_B1B1, 1'b0, 1'b0, 1'b0, 10'b00_01_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hB1B1_B1B1));
        vecs.push_back(mk(1'b1, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        // rr_ptr back at 0: ch0 wins although ch0 was granted last
        vecs.push_back(mk(1'b0, 2'b11, 2'b00, 2'd2, 32'h0000_0300, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b01_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd2, 32'h0000_0300, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_1_0_0_0_0, 4'd0, 4'd0, 3'd2, 32'h0000_0300, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1, 32'hC0C0_C0C0, 1'b0, 1'b0, 1'b0, 10'b00_01_1_0_1_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'hC0C0_C0C0));
        vecs.push_back(mk(1'b0, 2'b00, 2'b00, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'b00_00_0_0_0_0_0_0, 4'd0, 4'd0, 3'd0, 32'h0, 4'b0000, 32'h0));

        @(posedge clk); #1;
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            rst = v.rst;
            bus.req = v.req; bus.wr = v.wr; bus.size = {v.sz, v.sz}; bus.addr = {v.addr, v.addr};
            bus.len = {v.len, v.len}; bus.arready = v.ar_rdy; bus.rvalid = v.rv; bus.rlast = v.rl;
            bus.rdata = v.rd; bus.awready = v.aw_rdy; bus.wready = v.w_rdy; bus.bvalid = v.bv;
            #2;
            chk("handshakes", k, 32'({bus.addr_ok, bus.data_ok, bus.data_last, bus.arvalid, bus.rready,
                                      bus.awvalid, bus.wvalid, bus.bready}), 32'(v.hs));
            if (v.hs[4]) begin
                chk("arid", k, 32'(bus.arid), 32'(v.id));
                chk("arlen", k, 32'(bus.arlen), 32'(v.eln));
                chk("arsize", k, 32'(bus.arsize), 32'(v.esz));
                chk("araddr", k, bus.araddr, v.ead);
                chk("arburst", k, 32'(bus.arburst), 32'd1);
            end
            if (v.hs[2]) begin
                chk("awid", k, 32'(bus.awid), 32'(v.id));
                chk("awlen", k, 32'(bus.awlen), 32'(v.eln));
                chk("awsize", k, 32'(bus.awsize), 32'(v.esz));
                chk("awaddr", k, bus.awaddr, v.ead);
                chk("awburst", k, 32'(bus.awburst), 32'd1);
            end
            if (v.hs[1]) begin
                chk("wid", k, 32'(bus.wid), 32'(v.id));
                chk("wstrb", k, 32'(bus.wstrb), 32'(v.strb));
                chk("wdata", k, bus.axi_wdata, 32'h1122_3344);
                chk("wlast", k, 32'(bus.wlast), 32'd1);
            end
            if (v.hs[7:6] != 2'b00 && !v.hs[0]) begin
                chk("rdata_o", k, bus.rdata_o, v.rdo);
            end
            @(posedge clk); #1;
        end
        chk("tied_zero", -1, 32'({bus.arlock, bus.awlock, bus.arcache, bus.awcache, bus.arprot, bus.awprot}), 32'd0);

        // 4-channel, ID_BASE=4: ch3 then wrap to ch1
        bus4.req = 4'b1000;
        #2; chk("dut4_addr_ok_ch3", -1, 32'(bus4.addr_ok), 32'h8);
        @(posedge clk); #1;
        bus4.req = 4'b0000; bus4.arready = 1'b1;
        #2; chk("dut4_arvalid", -1, 32'(bus4.arvalid), 32'd1);
        chk("dut4_arid_ch3", -1, 32'(bus4.arid), 32'd7);
        chk("dut4_araddr_ch3", -1, bus4.araddr, 32'h0000_3000);
        @(posedge clk); #1;
        bus4.arready = 1'b0; bus4.rvalid = 1'b1; bus4.rlast = 1'b1; bus4.rdata = 32'h7777_7777;
        #2; chk("dut4_data_ok_ch3", -1, 32'({bus4.data_ok, bus4.data_last}), 32'b1000_1);
        chk("dut4_rdata_o", -1, bus4.rdata_o, 32'h7777_7777);
        @(posedge clk); #1;
        bus4.rvalid = 1'b0; bus4.rlast = 1'b0; bus4.req = 4'b1010;
        #2; chk("dut4_addr_ok_wrap", -1, 32'(bus4.addr_ok), 32'h2);
        @(posedge clk); #1;
        bus4.req = 4'b0000; bus4.arready = 1'b1;
        #2; chk("dut4_arid_ch1", -1, 32'(bus4.arid), 32'd5);
        chk("dut4_araddr_ch1", -1, bus4.araddr, 32'h0000_1000);
        @(posedge clk); #1;
        bus4.arready = 1'b0; bus4.rvalid = 1'b1; bus4.rlast = 1'b1;
        #2; chk("dut4_data_ok_ch1", -1, 32'({bus4.data_ok, bus4.data_last}), 32'b0010_1);
        @(posedge clk); #1;
        bus4.rvalid = 1'b0; bus4.rlast = 1'b0;
        #2; chk("dut4_idle", -1, 32'({bus4.rready, bus4.arvalid}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_like_axi_arbiter.md
Name: sram_like_axi_arbiter

Overview:
- N-channel successor to the fixed two-port (inst/data) sram-like-to-AXI3 bridge.
- Accepts NUM_CH sram-like master ports: I-side, D-side and future cache-refill or uncached ports.
- Arbitrates round-robin and issues one AXI3 transaction at a time.
- Adds incrementing read bursts (per-request length) for cache-line refill, and per-beat data_ok with a last-beat flag.

Parameters:
NUM_CH, 2, number of sram-like master ports (1..8); CH_W = max(1,$clog2(NUM_CH)) is internal.
ID_BASE, 0, arid/awid = ID_BASE + granted channel index; ID_BASE+NUM_CH-1 must be <= 15.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_CH  per-channel request
wr  in  NUM_CH  1 write, 0 read
size  in  2*NUM_CH  0 byte, 1 half, 2 word (3 treated as word)
addr  in  32*NUM_CH  byte address
wdata  in  32*NUM_CH  write data
len  in  4*NUM_CH  read burst beats minus 1 (ignored on writes)
addr_ok  out  NUM_CH  request accepted
data_ok  out  NUM_CH  read beat valid, or write response
rdata_o  out  32  shared read data, valid with data_ok
data_last  out  1  final read beat (or write response)
arid,araddr,arlen,arsize,arburst,arvalid  out  4,32,4,3,2,1  AXI AR channel
arready  in  1  AXI AR ready
rid,rdata,rresp,rlast,rvalid  in  4,32,2,1,1  AXI R channel
rready  out  1  AXI R ready
awid,awaddr,awlen,awsize,awburst,awvalid  out  4,32,4,3,2,1  AXI AW channel
awready  in  1  AXI AW ready
wid,wdata,wstrb,wlast,wvalid  out  4,32,4,1,1  AXI W channel
wready  in  1  AXI W ready
bid,bresp,bvalid  in  4,2,1  AXI B channel
bready  out  1  AXI B ready
arlock/awlock (2), arcache/awcache (4), arprot/awprot (3)  out  tied 0

Behaviour:
- Reset: state IDLE; rr_ptr=0.
- All valid, ready, addr_ok and data_ok outputs are 0 on reset.
- Captured registers (gnt, addr, size, wdata, len, wr) and the aw_done/w_done flags clear to 0.
- States are IDLE, AR, R, AW, B.
- IDLE arbitration:
  - Grant g is the first index starting at rr_ptr, wrapping, with req[g]=1.
  - addr_ok[g]=1 combinationally, exactly that cycle and one-hot.
  - On that cycle: capture the channel fields; rr_ptr <= (g+1) mod NUM_CH.
  - Next state is AW if wr, else AR. No req means stay in IDLE.
- AR:
  - arvalid=1, arid=ID_BASE+gnt, araddr=addr, arlen=len, arsize={0,size'} (size 3 maps to 2), arburst=2'b01.
  - arready handshake moves to R.
- R:
  - rready=1.
  - Each rvalid beat: data_ok[gnt]=1, rdata_o=rdata, data_last=rlast, all combinational.
  - rvalid&rlast moves to IDLE.
  - rresp and rid are not checked; beat count is not checked, only rlast ends the burst.
- AW:
  - awvalid and wvalid assert together; awlen=0, wlast=1, wid=awid=ID_BASE+gnt, wdata=captured wdata.
  - Each channel drops independently after its handshake (aw_done/w_done).
  - When both are done (same cycle allowed), move to B.
- wstrb:
  - size 0: 4'b0001<<addr[1:0].
  - size 1: 4'b0011<<{addr[1],1'b0}.
  - Otherwise: 4'b1111.
- B:
  - bready=1.
  - bvalid gives data_ok[gnt]=1 and data_last=1 for one cycle, then IDLE. bresp is ignored.
- Back-to-back: a new grant can occur on the cycle after return to IDLE, so there is a 1-cycle bubble.
- Minimum read latency: addr_ok on cycle 0, arvalid on cycle 1, data_ok on cycle 2 when arready and rvalid are immediate.
- A request cannot be cancelled after addr_ok. req deasserted while waiting loses nothing, because it was never granted.
- Address alignment is not checked. An unaligned word access is passed through unchanged.
- rst asserted mid-transaction forces IDLE on the next edge and drops all valids. The AXI slave must also be reset.

Test Plan:
- NUM_CH=2; ch0 read word at 0x1FC0_0000, len=0; arready and rvalid immediate; rdata=0xDEADBEEF → addr_ok[0] on cycle 0; arid=0, arlen=0, arsize=2 on cycle 1; data_ok[0]=1, data_last=1, rdata_o=0xDEADBEEF on cycle 2.
- ch1 burst read at 0x0000_0100, len=3 → arlen=3, arburst=01; four data_ok[1] pulses; data_last only on the 4th beat; return to IDLE afterwards.
- ch0 and ch1 both req continuously with reads → grants alternate 0,1,0,1; addr_ok is never two-hot.
- Writes, data 0x11223344:
  - sb to 0x...03 → wstrb=1000.
  - sh to 0x...02 → wstrb=1100.
  - sw → wstrb=1111.
  - awready delayed 3 cycles after wready → B is entered only after both handshakes; data_ok pulses once on bvalid.
- NUM_CH=4, ID_BASE=4; ch3 read → arid=7.
- Assert rst while in R with 2 of 4 beats done → next cycle: IDLE, rready=0, rr_ptr=0.
